// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// opcodes and datapath mux/ALU selector values.
package mc_ctrl_pkg;

  // State codes are visible on the debug display, so the values are fixed.
  typedef enum logic [3:0] {
    StInit    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRExec   = 4'd7,
    StRWb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StIExec   = 4'd11,
    StIWb     = 4'd12,
    StTrap    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: maps the current state to datapath controls.
// FETCH additionally gates IR/PC loads with mem_ready; I_EXEC picks the ALU
// class from op. Macro ILLEGAL_OP_TRAP_EN enables the TRAP state decode.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       illegal
);

  // Every control defaults low; each state raises only what it needs.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUsrcA     = 1'b0;
    ALUsrcB     = SRCB_RT;
    ALUop       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal     = 1'b0;
    case (state)
      StFetch: begin
        MemRead = 1'b1;
        ALUsrcB = SRCB_FOUR;
        // Only commit PC+4 and the new instruction once memory delivers.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: ALUsrcB = SRCB_IMMSH;
      StMemAddr: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_IMM;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRExec: begin
        ALUsrcA = 1'b1;
        ALUop   = ALUOP_FUNCT;
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUsrcA     = 1'b1;
        ALUop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      StIExec: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_IMM;
        ALUop   = (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      end
      StIWb: RegWrite = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (Moore). Sequences fetch/decode/execute/
// memory/writeback and waits on mem_ready. With ILLEGAL_OP_TRAP_EN defined,
// unknown opcodes lock the FSM in TRAP until reset; otherwise they act as NOPs.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [1:0]         PCSource,
  output logic [STATE_W-1:0] state_dbg,
  output logic               illegal
);

  state_e state_q, state_d;

  // State register; reset forces INIT at once, even mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StInit;
    else        state_q <= state_d;
  end

  // Next-state logic; op is held stable by the IR for the whole instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OP_RTYPE:       state_d = StRExec;
          OP_LW, OP_SW:   state_d = StMemAddr;
          OP_BEQ:         state_d = StBranch;
          OP_J:           state_d = StJump;
          OP_ADDI, OP_ORI: state_d = StIExec;
`ifdef ILLEGAL_OP_TRAP_EN
          default:        state_d = StTrap;
`else
          default:        state_d = StFetch;
`endif
        endcase
      end
      StMemAddr: state_d = (op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRExec:   state_d = StRWb;
      StRWb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StIExec:   state_d = StIWb;
      StIWb:     state_d = StFetch;
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap:    state_d = StTrap;
`endif
      // Unused codes recover through INIT.
      default:   state_d = StInit;
    endcase
  end

  assign state_dbg = state_q;

  // Output decode of the current state.
  mc_ctrl_outdec u_outdec (
    .state       (state_q),
    .op          (op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemToReg    (MemToReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUsrcA     (ALUsrcA),
    .ALUsrcB     (ALUsrcB),
    .ALUop       (ALUop),
    .PCSource    (PCSource),
    .illegal     (illegal)
  );

endmodule
